// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and default sizing for the branch resolve queue and the
// two-bit direction predictor it feeds.
package branch_resolve_queue_pkg;

  localparam int BRQ_DEPTH = 4;
  localparam int BRQ_IDX_W = 4;

  // One in-flight predicted branch: predictor table index plus predicted direction
  typedef struct packed {
    logic [BRQ_IDX_W-1:0] idx;
    logic                 pred;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/resolve/update bundle between the pipeline and the branch resolve queue.
interface branch_resolve_queue_if
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int IDX_W = BRQ_IDX_W
) ();

  logic                       fetch_valid;
  logic [IDX_W-1:0]           fetch_idx;
  logic                       fetch_prediction;
  logic                       fetch_ready;
  logic                       resolve_valid;
  logic                       resolve_taken;
  logic                       update_valid;
  logic                       update_taken;
  logic [IDX_W-1:0]           update_idx;
  logic                       mispredict;
  logic [$clog2(DEPTH+1)-1:0] count;

  // Pipeline side: presents branches and resolutions, consumes updates
  modport master (
    output fetch_valid, fetch_idx, fetch_prediction,
    output resolve_valid, resolve_taken,
    input  fetch_ready, update_valid, update_taken, update_idx, mispredict, count
  );

  // Queue side
  modport slave (
    input  fetch_valid, fetch_idx, fetch_prediction,
    input  resolve_valid, resolve_taken,
    output fetch_ready, update_valid, update_taken, update_idx, mispredict, count
  );

endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted conditional branches; emits a registered predictor
// update on each resolve and flushes younger wrong-path entries on a mispredict.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int IDX_W = BRQ_IDX_W
) (
  input logic                   clock,
  input logic                   reset,
  branch_resolve_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             pred;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_inc;
  logic [PTR_W-1:0] head_next;
  logic [PTR_W-1:0] tail_next;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             ready;
  logic             push;
  logic             pop;
  logic             wrong_path;
  logic             write_en;

  // Readiness looks only at the registered count, so a full queue refuses
  // a push even when a pop frees a slot in the same cycle.
  assign ready      = (count_q < CNT_W'(DEPTH));
  assign head_entry = mem[head];
  assign head_inc   = head + PTR_W'(1);

  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    wrong_path = 1'b0;
    write_en   = 1'b0;
    head_next  = head;
    tail_next  = tail;
    count_next = count_q;

    push = bus.fetch_valid && ready;
    pop  = bus.resolve_valid && (count_q != '0);

    if (pop) begin
      wrong_path = (head_entry.pred != bus.resolve_taken);
      head_next  = head_inc;
    end

    // A mispredict discards every younger entry, including a same-cycle push
    if (wrong_path) begin
      tail_next  = head_inc;
      count_next = '0;
    end else begin
      write_en   = push;
      if (push) begin
        tail_next = tail + PTR_W'(1);
      end
      count_next = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head_next;
      tail    <= tail_next;
      count_q <= count_next;
    end
  end

  // Entry storage carries no reset; slots outside [head, head+count) are never read
  always_ff @(posedge clock) begin
    if (!reset && write_en) begin
      mem[tail] <= '{idx: bus.fetch_idx, pred: bus.fetch_prediction};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.update_valid <= 1'b0;
      bus.update_taken <= 1'b0;
      bus.update_idx   <= '0;
      bus.mispredict   <= 1'b0;
    end else begin
      bus.update_valid <= pop;
      bus.update_taken <= pop && bus.resolve_taken;
      bus.update_idx   <= pop ? head_entry.idx : '0;
      bus.mispredict   <= wrong_path;
    end
  end

  assign bus.fetch_ready = ready;
  assign bus.count       = count_q;

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue of in-flight predicted conditional branches, sitting between fetch/predict and the two-bit direction predictor's update port. Fetch pushes each predicted branch (table index plus predicted direction). Execute resolves the oldest branch. The queue then emits a one-cycle registered update (`update_valid`/`update_taken`/`update_idx`) that drives the predictor's `transition`/`taken` inputs, plus a `mispredict` pulse. A mispredict flushes all younger wrong-path entries.

## Interface
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `IDX_W`, default 4: predictor table index width.
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_valid` in 1: a predicted branch is presented this cycle.
- `fetch_idx` in IDX_W: predictor index of that branch.
- `fetch_prediction` in 1: predicted direction; 1 = taken.
- `fetch_ready` out 1: queue can accept an entry (count < DEPTH).
- `resolve_valid` in 1: the oldest outstanding branch resolved this cycle.
- `resolve_taken` in 1: actual direction of that branch.
- `update_valid` out 1: registered; the predictor update strobe (predictor `transition`).
- `update_taken` out 1: registered; actual direction (predictor `taken`).
- `update_idx` out IDX_W: registered; index of the resolved branch.
- `mispredict` out 1: registered; the resolved direction differed from the stored prediction.
- `count` out $clog2(DEPTH+1): current occupancy.

## Operation
- **Storage.** Circular buffer of DEPTH entries {idx, pred}.
  - Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - A separate count register distinguishes full from empty.
- **Push.** Occurs when `fetch_valid && fetch_ready`.
  - Writes the entry at tail, then advances tail.
  - `fetch_valid` while `!fetch_ready` is dropped; upstream must stall.
- **Pop.** Occurs when `resolve_valid && count != 0`.
  - Reads the entry at head and advances head.
  - Next cycle: `update_valid` = 1, `update_taken` = `resolve_taken`, `update_idx` = head.idx, `mispredict` = (head.pred != `resolve_taken`).
- **Empty resolve.** `resolve_valid` with count == 0 is ignored: no update and no state change.
- **Mispredicting pop (flush).**
  - Every remaining entry is discarded: count becomes 0 and tail is set to the new head.
  - A push in the same cycle is also discarded, because it is wrong-path.
- **Correct pop with simultaneous push.** Both take effect; count is unchanged.
- **`fetch_ready`.** Derived from the registered count only (count < DEPTH).
  - A full queue refuses a push even if a pop occurs in the same cycle.
- **Pulses.** `update_*` and `mispredict` hold for exactly one cycle per pop and are 0 otherwise.
  - `update_taken` and `update_idx` are zeroed when `update_valid` = 0.

## Timing
- **Reset.** During a cycle with `reset` high, the next state is:
  - head = tail = count = 0;
  - `update_valid`, `update_taken`, `update_idx` and `mispredict` all 0;
  - `fetch_ready` = 1.
- **Reset priority.** Reset overrides concurrent push and pop. Reset mid-operation discards all entries and any pending update.
- **Latency.** Resolve to update outputs is 1 cycle. Push to earliest possible pop of that entry is 1 cycle.
- **Throughput.** One push and one pop per cycle, sustained.
- **Entry RAM.** Written at the clock edge; read combinationally at head.
- **Wrap-around.** Pointers pass DEPTH-1 → 0 with no bubble.

## Structure
- **Shared package.** Holds `brq_entry_t` (a packed struct {idx, pred}) and the default DEPTH and IDX_W constants. The predictor table uses the same IDX_W.
- **Single module.** No sub-module; the pointer, count and flush logic is inline.
- **Downstream wiring.** `update_valid` connects to predictor `transition`, and `update_taken` connects to predictor `taken`.

## Test plan
- **Reset.** Assert reset for 2 cycles with `fetch_valid` = 1 → `count` = 0, `fetch_ready` = 1, all update outputs 0.
- **Fill and block.** Push 4 entries idx 1–4, all pred 1 → `count` = 4 and `fetch_ready` = 0. A 5th push is dropped; `count` stays 4.
- **In-order correct resolves.** Resolve taken 4 times → `update_idx` = 1, 2, 3, 4 on consecutive cycles, each a 1-cycle `update_valid` with `mispredict` = 0. `count` ends at 0.
- **Mispredict flush.** Push idx 5 (pred 1), 6, 7. Then resolve not-taken while also pushing idx 8 → next cycle `update_idx` = 5, `update_taken` = 0, `mispredict` = 1, and `count` = 0. A subsequent resolve produces no update.
- **Wrap-around with concurrent traffic.** Push and pop simultaneously every cycle for 10 cycles, all correct → `count` stays constant and `update_idx` matches the pushed order across the pointer wrap.
- **Reset mid-operation.** Reset with `count` = 3 and `resolve_valid` = 1 in the same cycle → no `update_valid` next cycle and `count` = 0.
